// File: rtl/control_fifo_if.sv
// control_fifo_pkg / control_fifo_if
// Package: state_type, the game command encoding shared by the queue and its consumer.
// Interface: the command-queue bus.
//   master (front end + game FSM side) drives usr_btn, rx_valid, rx_byte, flush, pop.
//   slave (control_fifo side) drives cmd, cmd_valid, count, overflow.
package control_fifo_pkg;
  typedef enum logic [2:0] {
    NONE       = 3'd0,
    LEFT       = 3'd1,
    RIGHT      = 3'd2,
    DOWN       = 3'd3,
    DROP       = 3'd4,
    HOLD       = 3'd5,
    ROTATE     = 3'd6,
    ROTATE_REV = 3'd7
  } state_type;
endpackage

interface control_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  import control_fifo_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [3:0]       usr_btn;
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic             flush;
  logic             pop;
  state_type        cmd;
  logic             cmd_valid;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output usr_btn, rx_valid, rx_byte, flush, pop,
    input  cmd, cmd_valid, count, overflow
  );

  modport slave (
    input  usr_btn, rx_valid, rx_byte, flush, pop,
    output cmd, cmd_valid, count, overflow
  );
endinterface

// File: rtl/control_fifo.sv
// control_fifo
// Merges UART keystrokes and button presses (with optional auto-repeat) into one
// ordered circular queue of state_type commands, popped by the game FSM.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset (same effect as flush, plus overflow=0)
//   bus    control_fifo_if.slave: usr_btn, rx_valid, rx_byte, flush, pop in;
//          cmd, cmd_valid, count, overflow out (all registered)
module control_fifo
  import control_fifo_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter logic [3:0]  REPEAT_MASK   = 4'b0111
) (
  input  logic          clk,
  input  logic          reset,
  control_fifo_if.slave bus
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);

  // ASCII decode, case-insensitive; NONE means "ignore this byte"
  function automatic state_type decode(input logic [7:0] b);
    case (b)
      8'h41, 8'h61:        decode = LEFT;
      8'h44, 8'h64:        decode = RIGHT;
      8'h57, 8'h77:        decode = DOWN;
      8'h53, 8'h73, 8'h20: decode = DROP;
      8'h43, 8'h63:        decode = HOLD;
      8'h58, 8'h78:        decode = ROTATE;
      8'h5A, 8'h7A:        decode = ROTATE_REV;
      default:             decode = NONE;
    endcase
  endfunction

  function automatic state_type btn_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    btn_cmd = RIGHT;
      2'd1:    btn_cmd = DOWN;
      2'd2:    btn_cmd = LEFT;
      default: btn_cmd = ROTATE;
    endcase
  endfunction

  state_type        mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_type        cmd_q, cmd_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       btn_q, btn_d, rise_q, rise_d, pend_q, pend_d;
  logic [REP_W-1:0] rep_cnt_q [4];
  logic [REP_W-1:0] rep_cnt_d [4];
  logic [3:0]       rep_act_q, rep_act_d, rep_first_q, rep_first_d;

  state_type  rx_cmd, pick_cmd, push_cmd, head;
  logic       rx_hit, push_req, push_ok, do_pop, full, empty, we;
  logic [3:0] pend_pick, pend_clr, fire;

  // Arbitration, repeat timers, FIFO pointer update and next registered outputs
  always_comb begin
    rx_cmd    = decode(bus.rx_byte);
    rx_hit    = bus.rx_valid && (rx_cmd != NONE);
    pick_cmd  = NONE;
    pend_pick = '0;
    // Scan high to low so the lowest-index pending button is the one left selected
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) begin
        pend_pick    = '0;
        pend_pick[i] = 1'b1;
        pick_cmd     = btn_cmd(2'(i));
      end
    end
    push_req = rx_hit || (|pend_q);
    push_cmd = rx_hit ? rx_cmd : pick_cmd;
    pend_clr = rx_hit ? 4'b0000 : pend_pick;

    full    = (count_q == CNT_W'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = bus.pop && !empty;
    push_ok = push_req && (!full || do_pop);
    ovf_d   = push_req && full && !do_pop;
    we      = push_ok;

    // Repeat timer: armed by a press edge, reloads on each fire, dropped on release
    fire = '0;
    for (int i = 0; i < 4; i++) begin
      rep_act_d[i]   = rep_act_q[i];
      rep_first_d[i] = rep_first_q[i];
      rep_cnt_d[i]   = rep_cnt_q[i];
      if (!REPEAT_MASK[i]) begin
        rep_act_d[i]   = 1'b0;
        rep_first_d[i] = 1'b0;
        rep_cnt_d[i]   = '0;
      end else if (rise_q[i]) begin
        rep_act_d[i]   = 1'b1;
        rep_first_d[i] = 1'b1;
        rep_cnt_d[i]   = REP_W'(1);
      end else if (rep_act_q[i] && btn_q[i]) begin
        if (rep_cnt_q[i] == (rep_first_q[i] ? REP_DLY : REP_PER)) begin
          fire[i]        = 1'b1;
          rep_first_d[i] = 1'b0;
          rep_cnt_d[i]   = REP_W'(1);
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
        end
      end else begin
        rep_act_d[i]   = 1'b0;
        rep_first_d[i] = 1'b0;
        rep_cnt_d[i]   = '0;
      end
    end

    // A source is consumed even when its push is dropped on overflow
    pend_d = (pend_q & ~pend_clr) | rise_q | fire;
    btn_d  = bus.usr_btn;
    rise_d = bus.usr_btn & ~btn_q;

    wp_d = push_ok ? wp_q + PTR_W'(1) : wp_q;
    rp_d = do_pop  ? rp_q + PTR_W'(1) : rp_q;
    case ({push_ok, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Next head: the entry being written this cycle if it lands under the new read pointer
    head    = (push_ok && (rp_d == wp_q)) ? push_cmd : mem_q[rp_d];
    valid_d = (count_d != '0);
    cmd_d   = valid_d ? head : NONE;

    // Flush discards this cycle's push/pop; held buttons are treated as already seen
    if (bus.flush) begin
      we      = 1'b0;
      ovf_d   = 1'b0;
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      valid_d = 1'b0;
      cmd_d   = NONE;
      pend_d  = '0;
      rise_d  = '0;
      btn_d   = bus.usr_btn;
      for (int i = 0; i < 4; i++) begin
        rep_act_d[i]   = 1'b0;
        rep_first_d[i] = 1'b0;
        rep_cnt_d[i]   = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      cmd_q       <= NONE;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      btn_q       <= bus.usr_btn;
      rise_q      <= '0;
      pend_q      <= '0;
      rep_act_q   <= '0;
      rep_first_q <= '0;
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= '0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      btn_q       <= btn_d;
      rise_q      <= rise_d;
      pend_q      <= pend_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end

  // Queue storage; needs no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (we && !reset) mem_q[wp_q] <= push_cmd;
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = valid_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_control_fifo.sv
// Directed bench for control_fifo (DEPTH=4, REPEAT_DELAY=10, REPEAT_PERIOD=4).
// Expected commands are queued at stimulus time and compared when popped.
module tb_control_fifo;
  import control_fifo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  state_type sb[$];

  control_fifo_if #(.DEPTH(4)) ifc ();

  control_fifo #(
    .DEPTH(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .REPEAT_MASK(4'b0111)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; a pop that will be accepted is checked against the scoreboard first
  task automatic tick();
    state_type e;
    if (ifc.pop && ifc.cmd_valid && !ifc.flush && !reset) begin
      if (sb.size() == 0) begin
        chk("sb_has_entry_on_pop", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("pop_head", 32'(ifc.cmd), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ifc.rx_valid = 1'b1;
    ifc.rx_byte  = b;
    tick();
    ifc.rx_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    ifc.pop = 1'b1;
    repeat (n) tick();
    ifc.pop = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"}, 32'(ifc.count), 32'd0);
    chk({tag, "_valid"}, 32'(ifc.cmd_valid), 32'd0);
    chk({tag, "_cmd"}, 32'(ifc.cmd), 32'(NONE));
  endtask

  initial begin
    ifc.usr_btn  = 4'b0000;
    ifc.rx_valid = 1'b0;
    ifc.rx_byte  = 8'h00;
    ifc.flush    = 1'b0;
    ifc.pop      = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk_empty("reset");
    chk("reset_ovf", 32'(ifc.overflow), 32'd0);

    // UART decode: "a","D"," ","x","q"
    sb.push_back(LEFT); send("a");
    chk("first_push_valid", 32'(ifc.cmd_valid), 32'd1);
    chk("first_push_cmd", 32'(ifc.cmd), 32'(LEFT));
    sb.push_back(RIGHT);  send("D");
    sb.push_back(DROP);   send(" ");
    sb.push_back(ROTATE); send("x");
    send("q");
    chk("uart_count", 32'(ifc.count), 32'd4);
    chk("ignored_no_ovf", 32'(ifc.overflow), 32'd0);
    drain(4);
    chk_empty("uart_drained");
    chk("uart_sb_left", 32'(sb.size()), 32'd0);

    // Overflow at DEPTH=4, then pop+push while full across the wrap
    sb.push_back(DOWN);       send("w");
    sb.push_back(DROP);       send("s");
    sb.push_back(HOLD);       send("c");
    sb.push_back(ROTATE_REV); send("z");
    send("A");
    chk("ovf_pulse", 32'(ifc.overflow), 32'd1);
    chk("ovf_count", 32'(ifc.count), 32'd4);
    chk("ovf_head", 32'(ifc.cmd), 32'(DOWN));
    tick();
    chk("ovf_one_cycle", 32'(ifc.overflow), 32'd0);
    ifc.pop = 1'b1;
    sb.push_back(RIGHT);
    send("d");
    ifc.pop = 1'b0;
    chk("full_pushpop_count", 32'(ifc.count), 32'd4);
    chk("full_pushpop_ovf", 32'(ifc.overflow), 32'd0);
    chk("full_pushpop_head", 32'(ifc.cmd), 32'(DROP));
    drain(4);
    chk_empty("wrap_drained");

    // Two buttons rising together: RIGHT then LEFT
    ifc.usr_btn = 4'b0101;
    sb.push_back(RIGHT); sb.push_back(LEFT);
    tick(); chk("btn_edge_n", 32'(ifc.count), 32'd0);
    tick(); chk("btn_edge_n1", 32'(ifc.count), 32'd0);
    tick(); chk("btn_edge_n2", 32'(ifc.count), 32'd1);
    chk("btn_first_cmd", 32'(ifc.cmd), 32'(RIGHT));
    tick(); chk("btn_edge_n3", 32'(ifc.count), 32'd2);
    ifc.usr_btn = 4'b0000;
    drain(2);
    chk_empty("btn_drained");

    // UART wins btn0's slot: DOWN, RIGHT, LEFT
    ifc.usr_btn = 4'b0101;
    tick(); tick();
    sb.push_back(DOWN); sb.push_back(RIGHT); sb.push_back(LEFT);
    send("w");
    chk("arb_uart_first", 32'(ifc.cmd), 32'(DOWN));
    tick(); tick();
    chk("arb_count", 32'(ifc.count), 32'd3);
    ifc.usr_btn = 4'b0000;
    drain(3);
    chk_empty("arb_drained");

    // Auto-repeat btn2 held 30 cycles: press + 5 repeats
    ifc.pop = 1'b1;
    ifc.usr_btn = 4'b0100;
    repeat (6) sb.push_back(LEFT);
    repeat (30) tick();
    ifc.usr_btn = 4'b0000;
    repeat (10) tick();
    chk("repeat_btn2_all_seen", 32'(sb.size()), 32'd0);
    chk("repeat_btn2_count", 32'(ifc.count), 32'd0);

    // btn3 has repeat disabled: a single ROTATE
    ifc.usr_btn = 4'b1000;
    sb.push_back(ROTATE);
    repeat (30) tick();
    ifc.usr_btn = 4'b0000;
    repeat (10) tick();
    ifc.pop = 1'b0;
    chk("norepeat_btn3_seen", 32'(sb.size()), 32'd0);
    chk("norepeat_btn3_count", 32'(ifc.count), 32'd0);

    // Flush with push and pop pending, button mid-press
    send("a"); send("d"); send("w");
    chk("preflush_count", 32'(ifc.count), 32'd3);
    ifc.usr_btn = 4'b0010;
    tick();
    ifc.flush = 1'b1; ifc.pop = 1'b1; ifc.rx_valid = 1'b1; ifc.rx_byte = "x";
    tick();
    ifc.flush = 1'b0; ifc.pop = 1'b0; ifc.rx_valid = 1'b0;
    chk_empty("flush");
    repeat (20) tick();
    chk("held_after_flush", 32'(ifc.count), 32'd0);
    ifc.usr_btn = 4'b0000;
    tick(); tick();
    ifc.usr_btn = 4'b0010;
    sb.push_back(DOWN);
    tick(); tick(); tick();
    chk("repress_count", 32'(ifc.count), 32'd1);
    chk("repress_cmd", 32'(ifc.cmd), 32'(DOWN));
    ifc.usr_btn = 4'b0000;
    drain(2);

    // Pop on empty, then push+pop on empty
    ifc.pop = 1'b1;
    tick();
    chk_empty("pop_empty");
    sb.push_back(HOLD);
    send("c");
    ifc.pop = 1'b0;
    chk("pushpop_empty_count", 32'(ifc.count), 32'd1);
    chk("pushpop_empty_cmd", 32'(ifc.cmd), 32'(HOLD));
    drain(1);
    chk("pushpop_empty_drained", 32'(sb.size()), 32'd0);

    // First repeat timing, then reset mid-repeat
    ifc.usr_btn = 4'b0100;
    repeat (12) tick();
    chk("repeat_before_first", 32'(ifc.count), 32'd1);
    tick();
    chk("repeat_first_time", 32'(ifc.count), 32'd2);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk_empty("midrepeat_reset");
    chk("midrepeat_reset_ovf", 32'(ifc.overflow), 32'd0);
    repeat (20) tick();
    chk("held_after_reset", 32'(ifc.count), 32'd0);
    ifc.usr_btn = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
